rom_mp: RTL and testbench

ROM_MP -- requirements
Module: rom_mp

---
 rtl/rom_mp_if.sv | 35 +++
 rtl/rom_mp.sv | 137 +++++++++++++
 tb/tb_rom_mp.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_mp_if.sv
// rom_mp_if : request/response bundle for the multi-port ROM.
//
// Parameters : NUM_PORTS, ADDRESS_WIDTH, WORD_WIDTH (must match rom_mp).
// Signals    : req_valid/req_ready/req_addr  - per-port read request
//              rsp_valid/rsp_ready/rsp_data  - per-port read response
//              rsp_err                       - per-port out-of-range flag,
//                                              present only with the macro
//                                              ROM_ADDR_CHECK_EN defined
// Port p of a packed vector uses slice [p*WIDTH +: WIDTH].
// Modports   : master (request producer / response consumer), slave (ROM).
interface rom_mp_if #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDRESS_WIDTH = 6,
  parameter int WORD_WIDTH    = 24
);
  logic [NUM_PORTS-1:0]               req_valid;
  logic [NUM_PORTS-1:0]               req_ready;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_addr;
  logic [NUM_PORTS-1:0]               rsp_valid;
  logic [NUM_PORTS-1:0]               rsp_ready;
  logic [NUM_PORTS*WORD_WIDTH-1:0]    rsp_data;
`ifdef ROM_ADDR_CHECK_EN
  logic [NUM_PORTS-1:0]               rsp_err;

  modport master (output req_valid, req_addr, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data, rsp_err);
  modport slave  (input  req_valid, req_addr, rsp_ready,
                  output req_ready, rsp_valid, rsp_data, rsp_err);
`else
  modport master (output req_valid, req_addr, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data);
  modport slave  (input  req_valid, req_addr, rsp_ready,
                  output req_ready, rsp_valid, rsp_data);
`endif
endinterface

// File: rtl/rom_mp.sv
// rom_mp : multi-port read-only memory with per-port pipelined reads,
// credit-based flow control and an output FIFO per port.
//
// Parameters : ROM_FILE      - coefficient image identifier; the words are
//                              generated by romWord() so the array is a pure
//                              constant; an empty name yields an all-zero ROM
//              LINES         - number of ROM words
//              ADDRESS_WIDTH - address bits per port
//              WORD_WIDTH    - data bits per word
//              NUM_PORTS     - independent read ports (1..4)
//              READ_LATENCY  - cycles from acceptance to response (1..4)
// Ports      : clk - clock, rising edge
//              rst - synchronous active-high reset
//              bus - rom_mp_if slave modport (request/response per port)
// Option     : define ROM_ADDR_CHECK_EN to return zero data with rsp_err=1
//              for addresses >= LINES; otherwise such reads return X.
module rom_mp #(
  parameter string ROM_FILE      = "encoder/dct.rom",
  parameter int    LINES         = 64,
  parameter int    ADDRESS_WIDTH = 6,
  parameter int    WORD_WIDTH    = 24,
  parameter int    NUM_PORTS     = 2,
  parameter int    READ_LATENCY  = 2
) (
  input  logic     clk,
  input  logic     rst,
  rom_mp_if.slave  bus
);
  localparam int Depth      = READ_LATENCY + 1;
  localparam int PtrW       = $clog2(Depth);
  localparam int CntW       = $clog2(Depth + 1);
  localparam bit BlankImage = (ROM_FILE == "");

  // Constant ROM image: multiplicative hash of the word index.
  function automatic logic [WORD_WIDTH-1:0] romWord(input logic [ADDRESS_WIDTH-1:0] idx);
    logic [31:0] h;
    h = 32'(idx) * 32'h9E37_79B1;
    return BlankImage ? '0 : WORD_WIDTH'(h >> 5);
  endfunction

  // Depth is not necessarily a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // Holds req_ready low during reset and releases it on the first edge
  // that samples rst low.
  logic readyEn_q;

  always_ff @(posedge clk) begin
    if (rst) readyEn_q <= 1'b0;
    else     readyEn_q <= 1'b1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     inRange;
    logic                     accept;
    logic                     pop;
    logic                     push;
    logic [WORD_WIDTH-1:0]    lookData;
    logic [READ_LATENCY-1:0]  pipeValid_q;
    logic [WORD_WIDTH-1:0]    pipeData_q [READ_LATENCY];
    logic [WORD_WIDTH-1:0]    fifoData_q [Depth];
    logic [PtrW-1:0]          wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CntW-1:0]          count_q, count_d, credit_q, credit_d;

    assign addr    = bus.req_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign inRange = int'(addr) < LINES;

`ifdef ROM_ADDR_CHECK_EN
    assign lookData = inRange ? romWord(addr) : '0;
`else
    assign lookData = inRange ? romWord(addr) : 'x;
`endif

    // Credit covers in-flight plus buffered responses, so the FIFO cannot
    // overflow; a pop in the same cycle frees a slot for this acceptance.
    assign bus.req_ready[p] = readyEn_q && ((credit_q < CntW'(Depth)) || pop);
    assign accept           = bus.req_valid[p] && bus.req_ready[p];
    assign bus.rsp_valid[p] = (count_q != '0);
    assign pop              = bus.rsp_valid[p] && bus.rsp_ready[p];
    assign push             = pipeValid_q[READ_LATENCY-1];
    assign bus.rsp_data[p*WORD_WIDTH +: WORD_WIDTH] =
      bus.rsp_valid[p] ? fifoData_q[rdPtr_q] : 'x;

    always_ff @(posedge clk) begin
      if (rst) begin
        pipeValid_q <= '0;
      end else begin
        pipeValid_q[0] <= accept;
        for (int s = 1; s < READ_LATENCY; s++) pipeValid_q[s] <= pipeValid_q[s-1];
      end
    end

    // Data path carries no reset; validity is tracked by pipeValid_q/count_q.
    always_ff @(posedge clk) begin
      pipeData_q[0] <= lookData;
      for (int s = 1; s < READ_LATENCY; s++) pipeData_q[s] <= pipeData_q[s-1];
      if (push) fifoData_q[wrPtr_q] <= pipeData_q[READ_LATENCY-1];
    end

    always_comb begin
      wrPtr_d  = push ? nextPtr(wrPtr_q) : wrPtr_q;
      rdPtr_d  = pop  ? nextPtr(rdPtr_q) : rdPtr_q;
      count_d  = count_q  + CntW'(push)   - CntW'(pop);
      credit_d = credit_q + CntW'(accept) - CntW'(pop);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wrPtr_q  <= '0;
        rdPtr_q  <= '0;
        count_q  <= '0;
        credit_q <= '0;
      end else begin
        wrPtr_q  <= wrPtr_d;
        rdPtr_q  <= rdPtr_d;
        count_q  <= count_d;
        credit_q <= credit_d;
      end
    end

`ifdef ROM_ADDR_CHECK_EN
    logic [READ_LATENCY-1:0] pipeErr_q;
    logic [Depth-1:0]        fifoErr_q;

    always_ff @(posedge clk) begin
      pipeErr_q[0] <= !inRange;
      for (int s = 1; s < READ_LATENCY; s++) pipeErr_q[s] <= pipeErr_q[s-1];
      if (push) fifoErr_q[wrPtr_q] <= pipeErr_q[READ_LATENCY-1];
    end

    assign bus.rsp_err[p] = bus.rsp_valid[p] && fifoErr_q[rdPtr_q];
`endif
  end
endmodule

// File: tb/tb_rom_mp.sv
// tb_rom_mp : self-checking bench for rom_mp. Two instances share clk/rst:
// dutA (4 ports, READ_LATENCY=2, LINES=64) and dutB (1 port,
// READ_LATENCY=1, LINES=48). Their ports form five "lanes" driven from one
// initial block and checked every cycle against a queue-based model of
// outstanding requests.
module tb_rom_mp;
  localparam int NL = 5;
  localparam int AW = 6;
  localparam int WW = 24;

  logic clk = 1'b0;
  logic rst;

  // 10 time-unit clock
  always #5 clk = ~clk;

  rom_mp_if #(.NUM_PORTS(4), .ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) busA ();
  rom_mp_if #(.NUM_PORTS(1), .ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) busB ();

  rom_mp #(.LINES(64), .ADDRESS_WIDTH(AW), .WORD_WIDTH(WW),
           .NUM_PORTS(4), .READ_LATENCY(2)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  rom_mp #(.LINES(48), .ADDRESS_WIDTH(AW), .WORD_WIDTH(WW),
           .NUM_PORTS(1), .READ_LATENCY(1)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  logic [NL-1:0]         reqValid, rspReady, reqReady, rspValid;
  logic [NL-1:0][AW-1:0] reqAddr;
  logic [NL-1:0][WW-1:0] rspData;

  // Lanes 0..3 map to dutA ports, lane 4 to dutB port 0
  assign busA.req_valid = reqValid[3:0];
  assign busB.req_valid = reqValid[4];
  assign busA.rsp_ready = rspReady[3:0];
  assign busB.rsp_ready = rspReady[4];
  assign busA.req_addr  = reqAddr[3:0];
  assign busB.req_addr  = reqAddr[4];
  assign reqReady = {busB.req_ready, busA.req_ready};
  assign rspValid = {busB.rsp_valid, busA.rsp_valid};
  assign rspData  = {busB.rsp_data,  busA.rsp_data};
`ifdef ROM_ADDR_CHECK_EN
  logic [NL-1:0] rspErr;
  assign rspErr = {busB.rsp_err, busA.rsp_err};
`endif

  // Reference model: accepted-but-not-yet-popped requests per lane
  typedef struct {
    int addr;
    int cyc;
  } pend_t;

  pend_t         pend [NL][$];
  int            latOf   [NL] = '{2, 2, 2, 2, 1};
  int            linesOf [NL] = '{64, 64, 64, 64, 48};
  int            refMem  [64];
  int            cyc;
  int            checks;
  int            failures;
  bit            readyEn;
  logic [NL-1:0] lastAccept;
  logic [NL-1:0] obsReady;
  int            obsAccept [NL];
  int            obsPop    [NL];
  int            obsValid  [NL];
  int            nextAddr  [NL];
  int            base      [NL];

  // Compare one observed value against the model's value
  task automatic checkOutput(input string tag, input int lane,
                             input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s lane=%0d observed=%h expected=%h", tag, lane, observed, expected);
    end
  endtask

  // One clock: check outputs at the falling edge, cross the rising edge,
  // then advance the model (pops, pushes, reset) and step past the edge
  task automatic applyStimulus();
    logic [NL-1:0] expValid, expReady, pop;
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      expValid[l] = (pend[l].size() > 0) && (cyc >= pend[l][0].cyc + latOf[l]);
      pop[l]      = expValid[l] && rspReady[l];
      expReady[l] = readyEn && ((pend[l].size() < latOf[l] + 1) || pop[l]);
      lastAccept[l] = expReady[l] && reqValid[l];
      obsReady[l] = reqReady[l];
      if (!rst) begin
        obsAccept[l] += int'(reqReady[l] && reqValid[l]);
        obsPop[l]    += int'(rspValid[l] && rspReady[l]);
      end
      obsValid[l] += int'(rspValid[l]);
      checkOutput("rsp_valid", l, 32'(rspValid[l]), 32'(expValid[l]));
      checkOutput("req_ready", l, 32'(reqReady[l]), 32'(expReady[l]));
      if (expValid[l] && pend[l][0].addr < linesOf[l])
        checkOutput("rsp_data", l, 32'(rspData[l]), refMem[pend[l][0].addr]);
`ifdef ROM_ADDR_CHECK_EN
      if (expValid[l]) begin
        checkOutput("rsp_err", l, 32'(rspErr[l]), 32'(pend[l][0].addr >= linesOf[l]));
        if (pend[l][0].addr >= linesOf[l])
          checkOutput("rsp_data_oob", l, 32'(rspData[l]), 32'd0);
      end
`endif
    end
    @(posedge clk);
    cyc++;
    for (int l = 0; l < NL; l++) begin
      if (rst) begin
        pend[l].delete();
        lastAccept[l] = 1'b0;
      end else begin
        if (pop[l]) void'(pend[l].pop_front());
        if (lastAccept[l]) pend[l].push_back('{int'(reqAddr[l]), cyc});
      end
    end
    readyEn = !rst;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] h;
      h = 32'(i) * 32'h9E37_79B1;
      refMem[i] = int'((h >> 5) & 32'h00FF_FFFF);
    end
    for (int l = 0; l < NL; l++) begin
      obsAccept[l] = 0;
      obsPop[l]    = 0;
      obsValid[l]  = 0;
    end

    // Reset: ready and valid low while rst is high, ready rises after
    rst = 1'b1; reqValid = '0; rspReady = '0; reqAddr = '0;
    repeat (2) @(posedge clk);
    #1;
    readyEn = 1'b0;
    cyc     = 0;
    repeat (2) applyStimulus();
    rst = 1'b0;
    applyStimulus();
    for (int l = 0; l < NL; l++) checkOutput("ready_after_rst", l, 32'(reqReady[l]), 32'd1);

    // Latency: single request to address 5 on lane 0
    $display("[TB] latency");
    rspReady = '1; reqValid[0] = 1'b1; reqAddr[0] = AW'(5);
    applyStimulus();
    reqValid = '0;
    repeat (4) applyStimulus();

    // Backpressure: continuous requests with rsp_ready low, then release
    $display("[TB] backpressure");
    rspReady = '0; reqValid = '1;
    for (int l = 0; l < NL; l++) begin
      nextAddr[l] = 0; reqAddr[l] = '0; base[l] = obsAccept[l];
    end
    repeat (6) begin
      applyStimulus();
      for (int l = 0; l < NL; l++) begin
        if (lastAccept[l]) nextAddr[l]++;
        reqAddr[l] = AW'(nextAddr[l]);
      end
    end
    for (int l = 0; l < NL; l++) begin
      checkOutput("bp_accepted", l, 32'(obsAccept[l] - base[l]), 32'(latOf[l] + 1));
      checkOutput("bp_ready_low", l, 32'(obsReady[l]), 32'd0);
    end
    rspReady = '1;
    repeat (8) begin
      applyStimulus();
      for (int l = 0; l < NL; l++) begin
        if (lastAccept[l]) nextAddr[l]++;
        reqAddr[l] = AW'(nextAddr[l]);
      end
    end
    reqValid = '0;
    repeat (5) applyStimulus();

    // Throughput: one request per cycle per lane, rsp_ready held high
    $display("[TB] throughput");
    for (int l = 0; l < NL; l++) begin
      base[l] = obsAccept[l]; nextAddr[l] = obsPop[l];
    end
    rspReady = '1; reqValid = '1;
    for (int i = 0; i < 64; i++) begin
      for (int l = 0; l < NL; l++) reqAddr[l] = AW'((i + l) % linesOf[l]);
      applyStimulus();
    end
    reqValid = '0;
    repeat (5) applyStimulus();
    for (int l = 0; l < NL; l++) begin
      checkOutput("tp_accepted", l, 32'(obsAccept[l] - base[l]), 32'd64);
      checkOutput("tp_responses", l, 32'(obsPop[l] - nextAddr[l]), 32'd64);
    end

    // Reset mid-flight: fill with rsp_ready low, pulse rst, nothing returns
    $display("[TB] reset mid-flight");
    rspReady = '0; reqValid = '1;
    for (int l = 0; l < NL; l++) reqAddr[l] = AW'(l + 9);
    repeat (4) applyStimulus();
    rst = 1'b1; reqValid = '0;
    applyStimulus();
    rst = 1'b0; rspReady = '1;
    for (int l = 0; l < NL; l++) obsValid[l] = 0;
    repeat (4) applyStimulus();
    for (int l = 0; l < NL; l++) begin
      checkOutput("post_rst_no_valid", l, 32'(obsValid[l]), 32'd0);
      checkOutput("post_rst_ready", l, 32'(obsReady[l]), 32'd1);
    end

    // Randomised traffic with occasional reset pulses
    $display("[TB] random");
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int l = 0; l < NL; l++) begin
        reqValid[l] = ($urandom_range(0, 3) != 0);
        rspReady[l] = ($urandom_range(0, 2) != 0);
        reqAddr[l]  = AW'($urandom_range(0, 63));
      end
      applyStimulus();
    end
    rst = 1'b0; reqValid = '0; rspReady = '1;
    repeat (6) applyStimulus();

    // Same-cycle accept and pop at full credit on the latency-1 lane
    $display("[TB] accept+pop at full credit");
    rspReady[4] = 1'b0; reqValid[4] = 1'b1; reqAddr[4] = AW'(47);
    repeat (3) applyStimulus();
    checkOutput("full_ready_low", 4, 32'(obsReady[4]), 32'd0);
    rspReady[4] = 1'b1; reqAddr[4] = AW'(12);
    applyStimulus();
    checkOutput("full_pop_ready", 4, 32'(obsReady[4]), 32'd1);
    rspReady[4] = 1'b0;
    applyStimulus();
    checkOutput("credit_unchanged", 4, 32'(obsReady[4]), 32'd0);
    reqValid = '0; rspReady = '1;
    repeat (5) applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
